rv32i_decode_alu: RTL and testbench
===================================

RV32I_DECODE_ALU -- requirements
Module: rv32i_decode_alu

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low clears all registered outputs.
REQ-004 in_valid  input  1  instr/pc/rs1_data/rs2_data valid this cycle.
REQ-005 instr  input  32  RV32I instruction word.
REQ-006 pc  input  32  address of instr.
REQ-007 rs1_data, rs2_data  input  32 each  register-file values for rs1/rs2; caller supplies 0 for x0.
REQ-008 rs1, rs2  output  5 each  combinational instr[19:15], instr[24:20] (register-file read addresses).
REQ-009 out_valid  output  1  registered results below valid.
REQ-010 cls  output  10  registered one-hot {ALUreg, ALUimm, Branch, JAL, JALR, AUIPC, LUI, Load, Store, SYSTEM}; all zero for unknown opcode.
REQ-011 rd  output  5, funct3  output  3  registered fields.
REQ-012 result  output  32, reg_we  output  1  registered writeback value/enable.
REQ-013 next_pc  output  32  registered next program counter.
REQ-014 eq, lt, ltu, take_branch  output  1 each  registered compare flags.
REQ-015 mem_addr  output  32, store_data  output  32, store_mask  output  4  registered memory-access outputs.

Function
REQ-016 Opcodes SHALL decode: 0110011 ALUreg, 0010011 ALUimm, 1100011 Branch, 1101111 JAL, 1100111 JALR, 0010111 AUIPC, 0110111 LUI, 0000011 Load, 0100011 Store, 1110011 SYSTEM.
REQ-017 Immediates SHALL be standard RV32I I/S/B/U/J forms, sign-extended from instr[31]; B and J have bit0=0; U = instr[31:12]<<12.
REQ-018 ALU operand2 SHALL be rs2_data for ALUreg/Branch, else Iimm; shift amount = operand2[4:0].
REQ-019 ALU by funct3: 000 ADD (SUB only if ALUreg and instr[30]); 001 SLL; 010 SLT signed; 011 SLTU; 100 XOR; 101 SRL, or SRA if instr[30] (reg and imm); 110 OR; 111 AND; all modulo 2^32.
REQ-020 eq/lt/ltu SHALL compare rs1_data vs rs2_data (lt signed, ltu unsigned) for every instruction.
REQ-021 take_branch, Branch only: funct3 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu, 010/011 → 0.
REQ-022 result/reg_we: JAL/JALR pc+4; LUI Uimm; AUIPC pc+Uimm; ALUreg/ALUimm ALU out; all others result=0, reg_we=0; reg_we also 0 when rd=0.
REQ-023 next_pc: JAL pc+Jimm; JALR (rs1_data+Iimm) with bit0 cleared; taken Branch pc+Bimm; else pc+4.
REQ-024 mem_addr SHALL be rs1_data+Simm for Store, rs1_data+Iimm otherwise.
REQ-025 Store, by funct3: 000 byte replicated ×4, mask 0001<<addr[1:0]; 001 halfword replicated ×2, mask 0011 or 1100 by addr[1]; 010 rs2_data, mask 1111; other funct3 and non-store data 0, mask 0000.
REQ-026 Latency SHALL be exactly 1 cycle: out_valid = in_valid delayed one clock; registered outputs SHALL update only when in_valid=1 and hold otherwise.
REQ-027 Unknown opcode with in_valid=1 SHALL yield out_valid=1, cls=0, reg_we=0, next_pc=pc+4.

Reset
REQ-028 While reset low, out_valid, cls, reg_we, take_branch, flags, store_mask SHALL be 0 and all 32-bit outputs 0x00000000, taking effect immediately, including mid-operation.
REQ-029 First in_valid after reset release SHALL produce out_valid on the following edge.

Configuration
REQ-030 With ALU_TRACE_EN defined, each accepted instruction SHALL print "PC=<pc> <class>" in simulation; without it no trace logic exists and behaviour is otherwise identical.

Structure
REQ-031 A shared package rv32i_pkg SHALL hold the opcode constants, the instruction-class enum/one-hot typedef and the ALU funct3 constants.
REQ-032 Decoding SHALL live in one combinational sub-module rv32i_instr_decode; ALU, compare and writeback logic stay in the top.

Verification
REQ-033 instr 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 → result 12, reg_we=1, rd=3, next_pc=pc+4.
REQ-034 instr 0x402081B3 (sub), rs1=5, rs2=7 → result 0xFFFFFFFE, lt=1, ltu=1.
REQ-035 instr 0x4040D093 (srai x1,x1,4), rs1=0x80000000 → result 0xF8000000.
REQ-036 instr 0x00208463 (beq +8), pc=0x100, rs1=rs2=9 → take_branch=1, next_pc=0x108; rs2=8 → take_branch=0, next_pc=0x104, reg_we=0.
REQ-037 instr 0x003280E7 (jalr x1,3(x5)), pc=0x40, rs1=0x200 → next_pc=0x202, result 0x44, reg_we=1.
REQ-038 sb with rs2=0x000000AB, mem_addr=0x...3 → store_data 0xABABABAB, store_mask 1000; then drop reset low while out_valid=1 → all outputs 0 before next clock edge.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode constants, instruction-class one-hot
// encoding and ALU / branch / store funct3 constants.
package rv32i_pkg;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OP_ALUREG = 7'b0110011;
   localparam logic [6:0] OP_ALUIMM = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // Bit positions inside the class one-hot vector.
   // Ordered so that {ALUreg ... SYSTEM} reads MSB to LSB.
   typedef enum logic [3:0] {
      CLS_SYSTEM = 4'd0,
      CLS_STORE  = 4'd1,
      CLS_LOAD   = 4'd2,
      CLS_LUI    = 4'd3,
      CLS_AUIPC  = 4'd4,
      CLS_JALR   = 4'd5,
      CLS_JAL    = 4'd6,
      CLS_BRANCH = 4'd7,
      CLS_ALUIMM = 4'd8,
      CLS_ALUREG = 4'd9
   } cls_idx_e;

   typedef logic [9:0] cls_t;

   // ALU operations selected by funct3
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // Branch conditions selected by funct3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Store widths selected by funct3
   localparam logic [2:0] F3_SB   = 3'b000;
   localparam logic [2:0] F3_SH   = 3'b001;
   localparam logic [2:0] F3_SW   = 3'b010;

   // One-hot vector with only the given class bit set.
   function automatic cls_t cls_onehot(input cls_idx_e idx);
      return cls_t'(1) << idx;
   endfunction

endpackage

// File: rtl/rv32i_instr_decode.sv
// Purely combinational RV32I instruction decoder: class one-hot, register
// fields and all sign-extended immediate forms.
module rv32i_instr_decode
   import rv32i_pkg::*;
(
   input  logic [31:0] instr,
   output logic [9:0]  cls,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [2:0]  funct3,
   output logic        alt,
   output logic [31:0] imm_i,
   output logic [31:0] imm_s,
   output logic [31:0] imm_b,
   output logic [31:0] imm_u,
   output logic [31:0] imm_j
);

   // Register and function fields sit at fixed positions in every format.
   always_comb begin
      rd     = instr[11:7];
      funct3 = instr[14:12];
      rs1    = instr[19:15];
      rs2    = instr[24:20];
      alt    = instr[30];
   end

   // Immediates, all sign-extended from instr[31].
   always_comb begin
      imm_i = {{20{instr[31]}}, instr[31:20]};
      imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      imm_u = {instr[31:12], 12'b0};
      imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   end

   // Opcode to class one-hot; unknown opcodes leave every class bit clear.
   always_comb begin
      cls = '0;
      unique case (instr[6:0])
         OP_ALUREG: cls = cls_onehot(CLS_ALUREG);
         OP_ALUIMM: cls = cls_onehot(CLS_ALUIMM);
         OP_BRANCH: cls = cls_onehot(CLS_BRANCH);
         OP_JAL:    cls = cls_onehot(CLS_JAL);
         OP_JALR:   cls = cls_onehot(CLS_JALR);
         OP_AUIPC:  cls = cls_onehot(CLS_AUIPC);
         OP_LUI:    cls = cls_onehot(CLS_LUI);
         OP_LOAD:   cls = cls_onehot(CLS_LOAD);
         OP_STORE:  cls = cls_onehot(CLS_STORE);
         OP_SYSTEM: cls = cls_onehot(CLS_SYSTEM);
         default:   cls = '0;
      endcase
   end

endmodule

// File: rtl/rv32i_decode_alu.sv
// RV32I decode + ALU stage with one cycle of latency: decodes the instruction,
// computes ALU result, compare flags, branch decision, next PC, writeback and
// store data/mask, and registers everything when in_valid is high.
// Optional: define ALU_TRACE_EN to print "PC=<pc> <class>" per accepted
// instruction in simulation.
module rv32i_decode_alu
   import rv32i_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic        out_valid,
   output logic [9:0]  cls,
   output logic [4:0]  rd,
   output logic [2:0]  funct3,
   output logic [31:0] result,
   output logic        reg_we,
   output logic [31:0] next_pc,
   output logic        eq,
   output logic        lt,
   output logic        ltu,
   output logic        take_branch,
   output logic [31:0] mem_addr,
   output logic [31:0] store_data,
   output logic [3:0]  store_mask
);

   logic [9:0]  dec_cls;
   logic [4:0]  dec_rd;
   logic [2:0]  dec_funct3;
   logic        dec_alt;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   rv32i_instr_decode u_decode (
      .instr  (instr),
      .cls    (dec_cls),
      .rd     (dec_rd),
      .rs1    (rs1),
      .rs2    (rs2),
      .funct3 (dec_funct3),
      .alt    (dec_alt),
      .imm_i  (imm_i),
      .imm_s  (imm_s),
      .imm_b  (imm_b),
      .imm_u  (imm_u),
      .imm_j  (imm_j)
   );

   logic is_alureg, is_aluimm, is_branch, is_jal, is_jalr;
   logic is_auipc, is_lui, is_store;

   assign is_alureg = dec_cls[CLS_ALUREG];
   assign is_aluimm = dec_cls[CLS_ALUIMM];
   assign is_branch = dec_cls[CLS_BRANCH];
   assign is_jal    = dec_cls[CLS_JAL];
   assign is_jalr   = dec_cls[CLS_JALR];
   assign is_auipc  = dec_cls[CLS_AUIPC];
   assign is_lui    = dec_cls[CLS_LUI];
   assign is_store  = dec_cls[CLS_STORE];

   // Combinational results of this stage, before the output registers.
   logic [31:0] alu_op2, alu_out;
   logic [4:0]  shamt;
   logic        eq_c, lt_c, ltu_c, take_branch_c;
   logic [31:0] result_c, next_pc_c, mem_addr_c, store_data_c;
   logic        reg_we_c, writes_rd;
   logic [3:0]  store_mask_c;

   // ALU: second operand is rs2 for register ops and branches, else I-imm.
   always_comb begin
      alu_op2 = (is_alureg || is_branch) ? rs2_data : imm_i;
      shamt   = alu_op2[4:0];
      alu_out = '0;
      unique case (dec_funct3)
         F3_ADD:  alu_out = (is_alureg && dec_alt) ? (rs1_data - alu_op2) : (rs1_data + alu_op2);
         F3_SLL:  alu_out = rs1_data << shamt;
         F3_SLT:  alu_out = {31'b0, $signed(rs1_data) < $signed(alu_op2)};
         F3_SLTU: alu_out = {31'b0, rs1_data < alu_op2};
         F3_XOR:  alu_out = rs1_data ^ alu_op2;
         F3_SR:   alu_out = dec_alt ? 32'($signed(rs1_data) >>> shamt) : (rs1_data >> shamt);
         F3_OR:   alu_out = rs1_data | alu_op2;
         F3_AND:  alu_out = rs1_data & alu_op2;
         default: alu_out = '0;
      endcase
   end

   // Register compare flags (computed for every instruction) and branch decision.
   always_comb begin
      eq_c          = (rs1_data == rs2_data);
      lt_c          = ($signed(rs1_data) < $signed(rs2_data));
      ltu_c         = (rs1_data < rs2_data);
      take_branch_c = 1'b0;
      if (is_branch) begin
         unique case (dec_funct3)
            F3_BEQ:  take_branch_c = eq_c;
            F3_BNE:  take_branch_c = !eq_c;
            F3_BLT:  take_branch_c = lt_c;
            F3_BGE:  take_branch_c = !lt_c;
            F3_BLTU: take_branch_c = ltu_c;
            F3_BGEU: take_branch_c = !ltu_c;
            default: take_branch_c = 1'b0;
         endcase
      end
   end

   // Writeback value/enable and next program counter.
   always_comb begin
      result_c  = '0;
      writes_rd = 1'b0;
      next_pc_c = pc + 32'd4;
      if (is_jal) begin
         result_c  = pc + 32'd4;
         writes_rd = 1'b1;
         next_pc_c = pc + imm_j;
      end else if (is_jalr) begin
         result_c  = pc + 32'd4;
         writes_rd = 1'b1;
         next_pc_c = (rs1_data + imm_i) & ~32'd1;
      end else if (is_lui) begin
         result_c  = imm_u;
         writes_rd = 1'b1;
      end else if (is_auipc) begin
         result_c  = pc + imm_u;
         writes_rd = 1'b1;
      end else if (is_alureg || is_aluimm) begin
         result_c  = alu_out;
         writes_rd = 1'b1;
      end else if (is_branch && take_branch_c) begin
         next_pc_c = pc + imm_b;
      end
      // x0 is hardwired to zero, so never request a write to it
      reg_we_c = writes_rd && (dec_rd != 5'd0);
   end

   // Memory address and store lane steering.
   always_comb begin
      mem_addr_c   = is_store ? (rs1_data + imm_s) : (rs1_data + imm_i);
      store_data_c = '0;
      store_mask_c = '0;
      if (is_store) begin
         unique case (dec_funct3)
            F3_SB: begin
               store_data_c = {4{rs2_data[7:0]}};
               store_mask_c = 4'b0001 << mem_addr_c[1:0];
            end
            F3_SH: begin
               store_data_c = {2{rs2_data[15:0]}};
               store_mask_c = mem_addr_c[1] ? 4'b1100 : 4'b0011;
            end
            F3_SW: begin
               store_data_c = rs2_data;
               store_mask_c = 4'b1111;
            end
            default: begin
               store_data_c = '0;
               store_mask_c = '0;
            end
         endcase
      end
   end

   // Output register state
   logic        out_valid_q, out_valid_d;
   logic [9:0]  cls_q, cls_d;
   logic [4:0]  rd_q, rd_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] result_q, result_d;
   logic        reg_we_q, reg_we_d;
   logic [31:0] next_pc_q, next_pc_d;
   logic        eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d;
   logic        take_branch_q, take_branch_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] store_data_q, store_data_d;
   logic [3:0]  store_mask_q, store_mask_d;

   // Load new results only for a valid instruction; otherwise hold.
   always_comb begin
      out_valid_d   = in_valid;
      cls_d         = cls_q;
      rd_d          = rd_q;
      funct3_d      = funct3_q;
      result_d      = result_q;
      reg_we_d      = reg_we_q;
      next_pc_d     = next_pc_q;
      eq_d          = eq_q;
      lt_d          = lt_q;
      ltu_d         = ltu_q;
      take_branch_d = take_branch_q;
      mem_addr_d    = mem_addr_q;
      store_data_d  = store_data_q;
      store_mask_d  = store_mask_q;
      if (in_valid) begin
         cls_d         = dec_cls;
         rd_d          = dec_rd;
         funct3_d      = dec_funct3;
         result_d      = result_c;
         reg_we_d      = reg_we_c;
         next_pc_d     = next_pc_c;
         eq_d          = eq_c;
         lt_d          = lt_c;
         ltu_d         = ltu_c;
         take_branch_d = take_branch_c;
         mem_addr_d    = mem_addr_c;
         store_data_d  = store_data_c;
         store_mask_d  = store_mask_c;
      end
   end

   // Output registers, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         cls_q         <= '0;
         rd_q          <= '0;
         funct3_q      <= '0;
         result_q      <= '0;
         reg_we_q      <= 1'b0;
         next_pc_q     <= '0;
         eq_q          <= 1'b0;
         lt_q          <= 1'b0;
         ltu_q         <= 1'b0;
         take_branch_q <= 1'b0;
         mem_addr_q    <= '0;
         store_data_q  <= '0;
         store_mask_q  <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         cls_q         <= cls_d;
         rd_q          <= rd_d;
         funct3_q      <= funct3_d;
         result_q      <= result_d;
         reg_we_q      <= reg_we_d;
         next_pc_q     <= next_pc_d;
         eq_q          <= eq_d;
         lt_q          <= lt_d;
         ltu_q         <= ltu_d;
         take_branch_q <= take_branch_d;
         mem_addr_q    <= mem_addr_d;
         store_data_q  <= store_data_d;
         store_mask_q  <= store_mask_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign cls         = cls_q;
   assign rd          = rd_q;
   assign funct3      = funct3_q;
   assign result      = result_q;
   assign reg_we      = reg_we_q;
   assign next_pc     = next_pc_q;
   assign eq          = eq_q;
   assign lt          = lt_q;
   assign ltu         = ltu_q;
   assign take_branch = take_branch_q;
   assign mem_addr    = mem_addr_q;
   assign store_data  = store_data_q;
   assign store_mask  = store_mask_q;

`ifdef ALU_TRACE_EN
   function automatic string cls_name(input logic [9:0] c);
      if (c[CLS_ALUREG]) return "ALUreg";
      if (c[CLS_ALUIMM]) return "ALUimm";
      if (c[CLS_BRANCH]) return "Branch";
      if (c[CLS_JAL])    return "JAL";
      if (c[CLS_JALR])   return "JALR";
      if (c[CLS_AUIPC])  return "AUIPC";
      if (c[CLS_LUI])    return "LUI";
      if (c[CLS_LOAD])   return "Load";
      if (c[CLS_STORE])  return "Store";
      if (c[CLS_SYSTEM]) return "SYSTEM";
      return "unknown";
   endfunction

   // Simulation trace of every accepted instruction.
   always_ff @(posedge clk) begin
      if (rst_n && in_valid) begin
         $display("PC=%08h %s", pc, cls_name(dec_cls));
      end
   end
`endif

endmodule

// File: tb/tb_rv32i_decode_alu.sv
// Self-checking bench for rv32i_decode_alu: directed vectors with literal
// expectations plus randomized instructions checked against a behavioural
// model through an expectation queue, and asynchronous reset checks.
module tb_rv32i_decode_alu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0;
   logic [4:0]  rs1, rs2;
   logic        out_valid;
   logic [9:0]  cls;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [31:0] result;
   logic        reg_we;
   logic [31:0] next_pc;
   logic        eq, lt, ltu, take_branch;
   logic [31:0] mem_addr, store_data;
   logic [3:0]  store_mask;

   rv32i_decode_alu dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr), .pc(pc),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1(rs1), .rs2(rs2),
      .out_valid(out_valid), .cls(cls), .rd(rd), .funct3(funct3),
      .result(result), .reg_we(reg_we), .next_pc(next_pc), .eq(eq), .lt(lt),
      .ltu(ltu), .take_branch(take_branch), .mem_addr(mem_addr),
      .store_data(store_data), .store_mask(store_mask)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0]  cls;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [31:0] result;
      logic        reg_we;
      logic [31:0] next_pc;
      logic        eq;
      logic        lt;
      logic        ltu;
      logic        take_branch;
      logic [31:0] mem_addr;
      logic [31:0] store_data;
      logic [3:0]  store_mask;
   } exp_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   exp_t hold_exp = '0;
   logic chk_v;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
      end
   endtask

   function automatic exp_t snap();
      exp_t s;
      s.cls = cls; s.rd = rd; s.funct3 = funct3; s.result = result;
      s.reg_we = reg_we; s.next_pc = next_pc; s.eq = eq; s.lt = lt;
      s.ltu = ltu; s.take_branch = take_branch; s.mem_addr = mem_addr;
      s.store_data = store_data; s.store_mask = store_mask;
      return s;
   endfunction

   // Behavioural reference: class index 9..0 = ALUreg..SYSTEM, -1 unknown.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [31:0] ii, si, bi, ui, ji, op2, alu;
      int c;
      bit we;
      e = '0;
      e.rd = ins[11:7];
      e.funct3 = ins[14:12];
      ii = {{20{ins[31]}}, ins[31:20]};
      si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ui = {ins[31:12], 12'h000};
      ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      case (ins[6:0])
         7'b0110011: c = 9;
         7'b0010011: c = 8;
         7'b1100011: c = 7;
         7'b1101111: c = 6;
         7'b1100111: c = 5;
         7'b0010111: c = 4;
         7'b0110111: c = 3;
         7'b0000011: c = 2;
         7'b0100011: c = 1;
         7'b1110011: c = 0;
         default:    c = -1;
      endcase
      if (c >= 0) e.cls = 10'd1 << c;
      e.eq  = (a == b);
      e.lt  = ($signed(a) < $signed(b));
      e.ltu = (a < b);
      op2 = (c == 9 || c == 7) ? b : ii;
      case (e.funct3)
         3'd0: alu = (c == 9 && ins[30]) ? a - op2 : a + op2;
         3'd1: alu = a << op2[4:0];
         3'd2: alu = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
         3'd3: alu = (a < op2) ? 32'd1 : 32'd0;
         3'd4: alu = a ^ op2;
         3'd5: alu = ins[30] ? 32'($signed(a) >>> op2[4:0]) : a >> op2[4:0];
         3'd6: alu = a | op2;
         default: alu = a & op2;
      endcase
      if (c == 7) begin
         case (e.funct3)
            3'd0: e.take_branch = e.eq;
            3'd1: e.take_branch = !e.eq;
            3'd4: e.take_branch = e.lt;
            3'd5: e.take_branch = !e.lt;
            3'd6: e.take_branch = e.ltu;
            3'd7: e.take_branch = !e.ltu;
            default: e.take_branch = 1'b0;
         endcase
      end
      we = 1'b0;
      e.next_pc = p + 4;
      case (c)
         6: begin e.result = p + 4; we = 1; e.next_pc = p + ji; end
         5: begin e.result = p + 4; we = 1; e.next_pc = (a + ii) & 32'hFFFF_FFFE; end
         3: begin e.result = ui; we = 1; end
         4: begin e.result = p + ui; we = 1; end
         9, 8: begin e.result = alu; we = 1; end
         7: if (e.take_branch) e.next_pc = p + bi;
         default: ;
      endcase
      e.reg_we = we && (e.rd != 0);
      e.mem_addr = (c == 1) ? a + si : a + ii;
      if (c == 1) begin
         case (e.funct3)
            3'd0: begin e.store_data = {4{b[7:0]}}; e.store_mask = 4'(1 << e.mem_addr[1:0]); end
            3'd1: begin e.store_data = {2{b[15:0]}}; e.store_mask = e.mem_addr[1] ? 4'b1100 : 4'b0011; end
            3'd2: begin e.store_data = b; e.store_mask = 4'b1111; end
            default: ;
         endcase
      end
      return e;
   endfunction

   // Drive one cycle of inputs at the falling edge and queue the expectation.
   task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      in_valid = v; instr = ins; pc = p; rs1_data = a; rs2_data = b;
      if (v) begin
         exp_q.push_back(model(ins, p, a, b));
         $display("txn pc=%08h instr=%08h rs1_data=%08h rs2_data=%08h", p, ins, a, b);
      end
      #1;
      check("rs1_addr", 32'(rs1), 32'(ins[19:15]));
      check("rs2_addr", 32'(rs2), 32'(ins[24:20]));
   endtask

   task automatic check_all_zero(input string tag);
      n_checks++;
      if (out_valid !== 1'b0 || snap() !== '0) begin
         n_fail++;
         $display("FAIL %s: out_valid=%0b outputs=%h required all zero", tag, out_valid, snap());
      end
   endtask

   // Compare process: out_valid follows in_valid by one clock; outputs match
   // the model for new instructions and hold otherwise.
   always @(posedge clk) begin
      chk_v = in_valid;
      if (rst_n) begin
         #1;
         check("out_valid", 32'(out_valid), 32'(chk_v));
         if (chk_v) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL queue: got empty required entry");
            end else begin
               hold_exp = exp_q.pop_front();
            end
         end
         n_checks++;
         if (snap() !== hold_exp) begin
            n_fail++;
            $display("FAIL outputs: got %h required %h", snap(), hold_exp);
         end
      end
   end

   logic [6:0]  ops [10];
   logic [31:0] r_ins, r_a, r_b;
   int          k;
   exp_t        m;

   initial begin
      ops = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1100111,
              7'b0010111, 7'b0110111, 7'b0000011, 7'b0100011, 7'b1110011};

      // Pin the model with hand-computed values.
      m = model(32'h002081B3, 32'h0, 32'd5, 32'd7);
      check("model_add", m.result, 32'd12);
      m = model(32'h4040D093, 32'h0, 32'h8000_0000, 32'h0);
      check("model_srai", m.result, 32'hF800_0000);
      m = model(32'h003280E7, 32'h40, 32'h200, 32'h0);
      check("model_jalr", m.next_pc, 32'h202);
      m = model(32'h002081A3, 32'h0, 32'h1000, 32'hAB);
      check("model_sb_mask", 32'(m.store_mask), 32'h8);

      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset_state");
      @(negedge clk);
      rst_n = 1'b1;

      // add x3,x1,x2
      drive(1, 32'h002081B3, 32'h10, 32'd5, 32'd7);
      @(posedge clk); #2;
      check("add_result", result, 32'd12);
      check("add_we", 32'(reg_we), 32'd1);
      check("add_rd", 32'(rd), 32'd3);
      check("add_next_pc", next_pc, 32'h14);
      check("add_cls", 32'(cls), 32'h200);
      // sub
      drive(1, 32'h402081B3, 32'h14, 32'd5, 32'd7);
      @(posedge clk); #2;
      check("sub_result", result, 32'hFFFF_FFFE);
      check("sub_lt", 32'(lt), 32'd1);
      check("sub_ltu", 32'(ltu), 32'd1);
      // srai x1,x1,4
      drive(1, 32'h4040D093, 32'h18, 32'h8000_0000, 32'h0);
      @(posedge clk); #2;
      check("srai_result", result, 32'hF800_0000);
      // beq +8 taken / not taken
      drive(1, 32'h00208463, 32'h100, 32'd9, 32'd9);
      @(posedge clk); #2;
      check("beq_taken", 32'(take_branch), 32'd1);
      check("beq_taken_pc", next_pc, 32'h108);
      drive(1, 32'h00208463, 32'h100, 32'd9, 32'd8);
      @(posedge clk); #2;
      check("beq_not_taken", 32'(take_branch), 32'd0);
      check("beq_not_taken_pc", next_pc, 32'h104);
      check("beq_we", 32'(reg_we), 32'd0);
      // jalr x1,3(x5)
      drive(1, 32'h003280E7, 32'h40, 32'h200, 32'h0);
      @(posedge clk); #2;
      check("jalr_next_pc", next_pc, 32'h202);
      check("jalr_result", result, 32'h44);
      check("jalr_we", 32'(reg_we), 32'd1);
      // unknown opcode
      drive(1, 32'h0000007F, 32'h300, 32'h0, 32'h0);
      @(posedge clk); #2;
      check("unk_cls", 32'(cls), 32'h0);
      check("unk_next_pc", next_pc, 32'h304);
      // sb x2,3(x1) then reset while out_valid is high
      drive(1, 32'h002081A3, 32'h50, 32'h1000, 32'h0000_00AB);
      @(posedge clk); #2;
      check("sb_addr", mem_addr, 32'h1003);
      check("sb_data", store_data, 32'hABAB_ABAB);
      check("sb_mask", 32'(store_mask), 32'h8);
      @(negedge clk);
      check("pre_reset_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      hold_exp = '0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized instructions against the model.
      for (int i = 0; i < 300; i++) begin
         r_ins = $urandom;
         k = $urandom_range(0, 10);
         if (k < 10) r_ins[6:0] = ops[k];
         r_a = $urandom;
         if ($urandom_range(0, 3) == 0) r_a = 32'($urandom_range(0, 7)) - 32'd4;
         r_b = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
         drive($urandom_range(0, 3) != 0, r_ins, $urandom, r_a, r_b);
      end
      drive(0, 32'h0, 32'h0, 32'h0, 32'h0);
      drive(0, 32'h0, 32'h0, 32'h0, 32'h0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
